// File: rtl/fifo_pkg.sv
// Types and helpers shared by the FIFO read-side logic.
// Covers the reader state encoding and the output-buffer admission test.
package fifo_pkg;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_BURST = 1'b1
    } rd_state_t;

    // True when one more read can be issued without overflowing the 2-entry buffer.
    function automatic logic has_room(
        input logic [1:0] occ,
        input logic       inflight,
        input logic       pop
    );
        logic [2:0] w_level;
        w_level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        return (w_level < 3'd2);
    endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry in-order valid/ready buffer.
// The head entry drives the stream outputs directly from registers.
module rd_skid_buf #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output logic [1:0]    o_occ,
    output logic          o_valid,
    output logic [DW-1:0] o_head
);

    logic [DW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_occ;
    logic          w_pop;

    assign w_pop   = i_pop && (r_occ != 2'd0);
    assign o_occ   = r_occ;
    assign o_valid = (r_occ != 2'd0);
    assign o_head  = r_mem[r_rd_ptr];

    // Storage and ring pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    // Occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side controller for the synchronous FIFO: decides when to pop, issues
// reads, absorbs the FIFO read latency and streams words out with a burst marker.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 32,
    parameter int BURST   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         fifo_data,
    input  logic [$clog2(DEPTH)-1:0] fifo_count,
    input  logic                     fifo_empty,
    output logic                     fifo_rd_en,
    input  logic                     flush,
    output logic [WIDTH-1:0]         m_data,
    output logic                     m_valid,
    output logic                     m_last,
    input  logic                     m_ready,
    output logic                     busy
);

    localparam int CW = $clog2(DEPTH);
    localparam int BW = $clog2(BURST + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] BURST_C   = CW'(BURST);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } beat_t;

    rd_state_t       r_state;
    rd_state_t       w_state_nxt;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_nxt;
    logic [BW-1:0]   r_burst_left;
    logic [BW-1:0]   w_burst_left_nxt;
    logic            r_inflight;
    logic            r_inflight_last;
    logic            w_rd_en;
    logic            w_start;
    logic            w_pop;
    logic [CW-1:0]   w_min;
    logic [1:0]      w_occ;
    logic            w_valid;
    beat_t           w_head;
    beat_t           w_push_beat;

    assign w_pop       = w_valid && m_ready;
    assign w_push_beat = '{last: r_inflight_last, data: fifo_data};

    // Next-state, timer and read-issue decisions.
    always_comb begin
        w_state_nxt      = r_state;
        w_timer_nxt      = r_timer;
        w_burst_left_nxt = r_burst_left;
        w_rd_en          = 1'b0;
        w_start          = 1'b0;
        w_min            = (fifo_count < BURST_C) ? fifo_count : BURST_C;
        case (r_state)
            RD_IDLE: begin
                w_start = (fifo_count != '0) &&
                          ((fifo_count >= BURST_C) || (r_timer == TIMEOUT_C) || flush);
                if (w_start) begin
                    w_state_nxt      = RD_BURST;
                    w_burst_left_nxt = w_min[BW-1:0];
                    w_timer_nxt      = '0;
                end else if (fifo_count == '0) begin
                    w_timer_nxt = '0;
                end else if ((fifo_count < BURST_C) && (r_timer != TIMEOUT_C)) begin
                    w_timer_nxt = r_timer + TW'(1);
                end else begin
                    w_timer_nxt = r_timer;
                end
            end
            RD_BURST: begin
                // A read only goes out if its word is guaranteed a buffer slot on arrival.
                w_rd_en = !rst && (r_burst_left != '0) && !fifo_empty &&
                          has_room(w_occ, r_inflight, w_pop);
                if (w_rd_en) begin
                    w_burst_left_nxt = r_burst_left - BW'(1);
                end else begin
                    w_burst_left_nxt = r_burst_left;
                end
                if (w_burst_left_nxt == '0) begin
                    w_state_nxt = RD_IDLE;
                end else begin
                    w_state_nxt = RD_BURST;
                end
            end
            default: begin
                w_state_nxt = RD_IDLE;
            end
        endcase
    end

    // Controller state, timer, burst counter and in-flight tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= RD_IDLE;
            r_timer         <= '0;
            r_burst_left    <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_timer         <= w_timer_nxt;
            r_burst_left    <= w_burst_left_nxt;
            r_inflight      <= w_rd_en;
            r_inflight_last <= w_rd_en && (r_burst_left == BW'(1));
        end
    end

    rd_skid_buf #(
        .DW(WIDTH + 1)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .i_push     (r_inflight),
        .i_push_data(w_push_beat),
        .i_pop      (w_pop),
        .o_occ      (w_occ),
        .o_valid    (w_valid),
        .o_head     (w_head)
    );

    assign fifo_rd_en = w_rd_en;
    assign m_valid    = w_valid;
    assign m_data     = w_head.data;
    assign m_last     = w_head.last;
    assign busy       = (r_state == RD_BURST) || r_inflight;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader with a behavioural registered-read FIFO.
module tb_fifo_burst_reader;
    import fifo_pkg::*;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 32;
    localparam int BURST   = 4;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(DEPTH);

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] fifo_data;
    logic [CW-1:0]    fifo_count;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic             flush;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;
    logic             busy;

    int checks;
    int failures;

    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] wr_pend[$];
    logic [WIDTH:0]   sb[$];
    logic             rd_q;

    fifo_burst_reader #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .BURST(BURST), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_count(fifo_count),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .flush(flush),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: read enable sampled at the edge, data and count settle mid-cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) rd_q <= 1'b0;
        else     rd_q <= fifo_rd_en;
    end

    always @(negedge clk) begin
        if (rd_q && (fq.size() > 0)) fifo_data = fq.pop_front();
        while (wr_pend.size() > 0) fq.push_back(wr_pend.pop_front());
        fifo_count = CW'(fq.size());
        fifo_empty = (fq.size() == 0);
    end

    task automatic test_reset();
        @(negedge clk); #1;
        checks++;
        if ({m_valid, m_data, m_last, busy, fifo_rd_en} !== {WIDTH+4{1'b0}}) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {m_valid, m_data, m_last, busy, fifo_rd_en});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({busy, m_valid} !== 2'b00 || dut.r_state !== RD_IDLE) begin
            failures++;
            $display("FAIL reset_release busy=%b m_valid=%b state=%0d", busy, m_valid, dut.r_state);
        end
    endtask

    task automatic test_burst();
        int first_rd = -1, last_rd = -1, n_rd = 0, first_v = -1, n_v = 0;
        logic [WIDTH:0] e;
        @(posedge clk); #1;
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wr_pend.push_back(WIDTH'(8'h11 + k));
            sb.push_back({(k == 3), WIDTH'(8'h11 + k)});
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (fifo_rd_en) begin
                if (first_rd < 0) first_rd = i;
                last_rd = i;
                n_rd++;
            end
            if (m_valid) begin
                if (first_v < 0) first_v = i;
                n_v++;
            end
            if (m_valid && m_ready) begin
                checks++;
                e = (sb.size() > 0) ? sb.pop_front() : '1;
                if ({m_last, m_data} !== e) begin
                    failures++;
                    $display("FAIL burst_beat got=%h exp=%h", {m_last, m_data}, e);
                end
            end
        end
        checks++;
        if (n_rd !== 4 || (last_rd - first_rd) !== 3) begin
            failures++;
            $display("FAIL burst_rd_en got=%0d span=%0d exp=4 span=3", n_rd, last_rd - first_rd);
        end
        checks++;
        if (n_v !== 4 || first_v !== first_rd + 2) begin
            failures++;
            $display("FAIL burst_valid got=%0d@%0d exp=4@%0d", n_v, first_v, first_rd + 2);
        end
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL burst_drain got=%0d left exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_timeout();
        int first_rd = -1, n_rd = 0;
        logic [WIDTH:0] e;
        @(posedge clk); #1;
        wr_pend.push_back(8'hA0); sb.push_back({1'b0, 8'hA0});
        wr_pend.push_back(8'hA1); sb.push_back({1'b1, 8'hA1});
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (fifo_rd_en) begin
                if (first_rd < 0) first_rd = i;
                n_rd++;
            end
            if (m_valid && m_ready) begin
                checks++;
                e = (sb.size() > 0) ? sb.pop_front() : '1;
                if ({m_last, m_data} !== e) begin
                    failures++;
                    $display("FAIL timeout_beat got=%h exp=%h", {m_last, m_data}, e);
                end
            end
        end
        checks++;
        if (first_rd !== 17 || n_rd !== 2) begin
            failures++;
            $display("FAIL timeout_start got=%0d/%0d exp=17/2", first_rd, n_rd);
        end
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL timeout_drain got=%0d left exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_flush();
        int n_rd = 0;
        logic [WIDTH:0] e;
        @(posedge clk); #1;
        wr_pend.push_back(8'h5C); sb.push_back({1'b1, 8'h5C});
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); #1;
            if (fifo_rd_en) n_rd++;
            if (m_valid && m_ready) begin
                checks++;
                e = (sb.size() > 0) ? sb.pop_front() : '1;
                if ({m_last, m_data} !== e) begin
                    failures++;
                    $display("FAIL flush_beat got=%h exp=%h", {m_last, m_data}, e);
                end
            end
        end
        checks++;
        if (n_rd !== 1 || sb.size() !== 0) begin
            failures++;
            $display("FAIL flush_count got=%0d reads %0d left exp=1 reads 0 left", n_rd, sb.size());
            sb.delete();
        end
        checks++;
        if (dut.r_timer !== '0) begin
            failures++;
            $display("FAIL flush_timer got=%0d exp=0", dut.r_timer);
        end
    endtask

    task automatic test_back_to_back();
        int n_stall = 0;
        logic [WIDTH:0] e;
        @(posedge clk); #1;
        m_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wr_pend.push_back(WIDTH'(8'h30 + k));
            sb.push_back({(k == 3 || k == 7), WIDTH'(8'h30 + k)});
        end
        for (int i = 0; i < 60; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
                if (i == 10) m_ready = 1'b1;
            end
            @(negedge clk); #1;
            if (i < 10 && fifo_rd_en) n_stall++;
            checks++;
            if (fifo_rd_en && fifo_empty) begin
                failures++;
                $display("FAIL bp_rd_on_empty cycle=%0d", i);
            end
            if (i == 9) begin
                checks++;
                if ({m_valid, m_last, m_data} !== {1'b1, 1'b0, 8'h30}) begin
                    failures++;
                    $display("FAIL bp_hold got=%h exp=%h", {m_valid, m_last, m_data}, {1'b1, 1'b0, 8'h30});
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                e = (sb.size() > 0) ? sb.pop_front() : '1;
                if ({m_last, m_data} !== e) begin
                    failures++;
                    $display("FAIL bp_beat got=%h exp=%h", {m_last, m_data}, e);
                end
            end
        end
        checks++;
        if (n_stall > 2) begin
            failures++;
            $display("FAIL bp_stall_reads got=%0d exp<=2", n_stall);
        end
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL bp_drain got=%0d left exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_empty_guard();
        @(posedge clk); #1;
        flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            @(negedge clk); #1;
            checks++;
            if ({fifo_rd_en, m_valid, busy} !== 3'b000) begin
                failures++;
                $display("FAIL empty_guard cycle=%0d got=%b exp=000", i, {fifo_rd_en, m_valid, busy});
            end
        end
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n_rd = 0;
        logic [WIDTH:0] e;
        @(posedge clk); #1;
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wr_pend.push_back(WIDTH'(8'h70 + k));
            sb.push_back({(k == 3), WIDTH'(8'h70 + k)});
        end
        for (int i = 0; i < 20 && n_rd < 2; i++) begin
            @(negedge clk); #1;
            if (fifo_rd_en) n_rd++;
            if (m_valid && m_ready) begin
                checks++;
                e = (sb.size() > 0) ? sb.pop_front() : '1;
                if ({m_last, m_data} !== e) begin
                    failures++;
                    $display("FAIL rstmid_beat got=%h exp=%h", {m_last, m_data}, e);
                end
            end
        end
        checks++;
        if (n_rd !== 2) begin
            failures++;
            $display("FAIL rstmid_second_rd got=%0d exp=2", n_rd);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({m_valid, m_data, m_last, busy, fifo_rd_en} !== {WIDTH+4{1'b0}}) begin
            failures++;
            $display("FAIL rstmid_outputs got=%h exp=0", {m_valid, m_data, m_last, busy, fifo_rd_en});
        end
        fq.delete();
        wr_pend.delete();
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (dut.r_state !== RD_IDLE || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_release state=%0d busy=%b exp=0/0", dut.r_state, busy);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        flush      = 1'b0;
        m_ready    = 1'b0;
        fifo_data  = '0;
        fifo_count = '0;
        fifo_empty = 1'b1;
        test_reset();
        test_burst();
        test_timeout();
        test_flush();
        test_back_to_back();
        test_empty_guard();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
